// File: rtl/trg_frame_tx.sv
// Trigger fiber TX framer: packs NWORDS*4-2 payload bytes plus a K-char separator into 32-bit GTX words.
// Payload source is DIN, PRBS-31, a counting pattern or idle; a sync burst of idle words follows reset.
module trg_frame_tx #(
  parameter int          NWORDS      = 2,
  parameter int          MARK_PERIOD = 256,
  parameter int          IDLE_CYCLES = 16,
  parameter logic [30:0] PRBS_SEED   = 31'h7FFFFFFF
) (
  input  logic                   TRG_CLK80,
  input  logic                   TRG_RST,
  input  logic [1:0]             MODE,
  input  logic [32*NWORDS-17:0]  DIN,
  output logic                   DIN_RD,
  input  logic                   INJ_ERR,
  output logic [31:0]            TX_DATA,
  output logic [3:0]             TX_ISK,
  output logic                   TX_ACTIVE,
  output logic                   LTNCY_TRIG,
  output logic [31:0]            FRM_CNT,
  output logic [15:0]            INJ_CNT
);

  localparam int PB = 32*NWORDS - 16;
  localparam int IW = $clog2(NWORDS);
  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam int MW = $clog2(MARK_PERIOD);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NWORDS - 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(IDLE_CYCLES - 1);
  localparam logic [31:0]   IDLE_WORD = 32'h50BC50BC;
  localparam logic [3:0]    IDLE_ISK  = 4'b0101;

  typedef enum logic {SYNC, RUN} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  idle_cnt;
  logic [30:0]    lfsr;
  logic [PB-1:0]  pay;
  logic [1:0]     mode_q;
  logic           inj_q;
  logic           pend;

  logic           capture;
  logic           inj_rise;
  logic           do_inj;
  logic           marker;
  logic [30:0]    lfsr_next;
  logic [PB-1:0]  prbs_bits;
  logic [PB-1:0]  p_next;
  logic [31:0]    mid_word;

  assign capture  = (state == SYNC) ? (idle_cnt == LAST_IDLE) : (idx == LAST_IDX);
  assign DIN_RD   = capture;
  assign inj_rise = INJ_ERR & ~inj_q;
  assign do_inj   = (state == RUN) && (MODE != 2'd3) && (pend || inj_rise);
  assign marker   = (FRM_CNT[MW-1:0] == '0);

  // Fibonacci PRBS-31: each step emits s[30]^s[27] and shifts it in at bit 0.
  // The LFSR continues only if the previous frame was PRBS; otherwise it restarts from the seed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    lfsr_next = (mode_q == 2'd1) ? lfsr : PRBS_SEED;
    prbs_bits = '0;
    for (int i = 0; i < PB; i++) begin
      prbs_bits[i] = lfsr_next[30] ^ lfsr_next[27];
      lfsr_next    = {lfsr_next[29:0], prbs_bits[i]};
    end
  end

  always_comb begin
    p_next = '0;
    case (MODE)
      2'd0: p_next = DIN;
      2'd1: p_next = prbs_bits;
      2'd2: for (int i = 0; i < PB/8; i++) p_next[8*i +: 8] = FRM_CNT[7:0] + 8'(i);
      default: p_next = '0;
    endcase
    if (do_inj) p_next[0] = ~p_next[0];
  end

  // Word k (k>=1) of the frame held in pay; idx is the word currently on TX_DATA.
  always_comb begin
    mid_word = '0;
    for (int k = 1; k < NWORDS; k++)
      if (idx == IW'(k - 1)) mid_word = pay[32*k-16 +: 32];
  end

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      state      <= SYNC;
      idx        <= '0;
      idle_cnt   <= '0;
      lfsr       <= PRBS_SEED;
      pay        <= '0;
      mode_q     <= 2'd0;
      inj_q      <= 1'b0;
      pend       <= 1'b0;
      TX_DATA    <= IDLE_WORD;
      TX_ISK     <= IDLE_ISK;
      TX_ACTIVE  <= 1'b0;
      LTNCY_TRIG <= 1'b0;
      FRM_CNT    <= '0;
      INJ_CNT    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
      inj_q      <= INJ_ERR;
      LTNCY_TRIG <= 1'b0;
      if (capture) begin
        state     <= RUN;
        TX_ACTIVE <= 1'b1;
        idx       <= '0;
        pay       <= p_next;
        mode_q    <= MODE;
        pend      <= 1'b0;
        FRM_CNT   <= FRM_CNT + 32'd1;
        if (MODE == 2'd1) lfsr <= lfsr_next;
        if (do_inj && INJ_CNT != 16'hFFFF) INJ_CNT <= INJ_CNT + 16'd1;
        if (MODE == 2'd3) begin
          TX_DATA <= IDLE_WORD;
          TX_ISK  <= IDLE_ISK;
        end else begin
          TX_DATA    <= {p_next[15:0], marker ? 16'h50FC : 16'h50BC};
          TX_ISK     <= 4'b0001;
          LTNCY_TRIG <= marker;
        end
      end else if (state == SYNC) begin
        idle_cnt <= idle_cnt + 1'b1;
        pend     <= 1'b0;
        TX_DATA  <= IDLE_WORD;
        TX_ISK   <= IDLE_ISK;
      end else begin
        idx  <= idx + 1'b1;
        pend <= pend | inj_rise;
        if (mode_q == 2'd3) begin
          TX_DATA <= IDLE_WORD;
          TX_ISK  <= IDLE_ISK;
        end else begin
          TX_DATA <= mid_word;
          TX_ISK  <= 4'b0000;
        end
      end
    end
  end

endmodule
